alu_issue: RTL and testbench

- ID/EX issue stage that sits directly upstream of the combinational ALU.
- Accepts decoded instructions from decode over a valid/ready handshake and reads both source registers from the register file.
- Resolves operands by forwarding from EX and MEM, and stalls on load-use hazards.
- Registers the opcode, operands, shift amount and destination; these registered outputs drive the ALU inputs directly.

---
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue.sv | 176 +++++++++++++++++
 tb/tb_alu_issue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_if
//  Description : Decode-to-issue handshake bus. Carries one decoded
//                instruction per transfer under valid/ready.
//                  master (decode) : drives valid and the instruction fields,
//                                    observes ready
//                  slave  (issue)  : observes valid and the fields,
//                                    drives ready
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_issue_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  valid;
  logic                  ready;
  logic [3:0]            opcode;
  logic [REG_ADDR_W-1:0] rs_a;
  logic [REG_ADDR_W-1:0] rs_b;
  logic [REG_ADDR_W-1:0] rd;
  logic                  use_imm;
  logic [31:0]           imm;
  logic [4:0]            shamt;
  logic                  shamt_src;

  modport master (
    output valid, opcode, rs_a, rs_b, rd, use_imm, imm, shamt, shamt_src,
    input  ready
  );

  modport slave (
    input  valid, opcode, rs_a, rs_b, rd, use_imm, imm, shamt, shamt_src,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : ID/EX issue stage feeding the combinational ALU. Reads both
//                sources from the register file, forwards from EX/MEM, stalls
//                on load-use hazards and registers the ALU operands.
//  Ports       : i_clk / i_rst_n   clock, synchronous active-low reset
//                dec               decode handshake (slave side)
//                o_rf_addr_a/b     register file read addresses
//                i_rf_data_a/b     register file read data (same cycle)
//                i_ex_* / i_mem_*  forwarding sources from EX and MEM
//                i_flush           branch redirect, kills the pending issue
//                o_alu_valid, i_alu_ready   output handshake to execute
//                o_opcode/o_wordA/o_wordB/o_shamt/o_rd/o_illegal  ALU payload
//                o_stall_count     saturating count of load-use stall cycles
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  alu_issue_if.slave             dec,
  output logic [REG_ADDR_W-1:0]  o_rf_addr_a,
  output logic [REG_ADDR_W-1:0]  o_rf_addr_b,
  input  logic [31:0]            i_rf_data_a,
  input  logic [31:0]            i_rf_data_b,
  input  logic                   i_ex_wr_en,
  input  logic [REG_ADDR_W-1:0]  i_ex_rd,
  input  logic [31:0]            i_ex_data,
  input  logic                   i_ex_is_load,
  input  logic                   i_mem_wr_en,
  input  logic [REG_ADDR_W-1:0]  i_mem_rd,
  input  logic [31:0]            i_mem_data,
  input  logic                   i_flush,
  output logic                   o_alu_valid,
  input  logic                   i_alu_ready,
  output logic [3:0]             o_opcode,
  output logic [31:0]            o_wordA,
  output logic [31:0]            o_wordB,
  output logic [4:0]             o_shamt,
  output logic [REG_ADDR_W-1:0]  o_rd,
  output logic                   o_illegal,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [3:0]             C_FIRST_ILLEGAL = 4'hD;
  localparam logic [REG_ADDR_W-1:0]  C_R0            = '0;
  localparam logic [STALL_CNT_W-1:0] C_STALL_MAX     = '1;

  state_t                 state_q, state_d;
  logic [3:0]             opcode_q, opcode_d;
  logic [31:0]            word_a_q, word_a_d;
  logic [31:0]            word_b_q, word_b_d;
  logic [4:0]             shamt_q, shamt_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;
  logic                   illegal_q, illegal_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [31:0] res_a;
  logic [31:0] res_b;
  logic        hazard;
  logic        ready;
  logic        accept;

  assign o_rf_addr_a = dec.rs_a;
  assign o_rf_addr_b = dec.rs_b;

  // Operand A resolution. A load in EX has no data yet, so it never forwards;
  // that case is covered by the hazard stall instead.
  always_comb begin
    res_a = i_rf_data_a;
    if (dec.rs_a == C_R0)
      res_a = '0;
    else if (i_ex_wr_en && (i_ex_rd == dec.rs_a) && !i_ex_is_load)
      res_a = i_ex_data;
    else if (i_mem_wr_en && (i_mem_rd == dec.rs_a))
      res_a = i_mem_data;
  end

  always_comb begin
    res_b = i_rf_data_b;
    if (dec.rs_b == C_R0)
      res_b = '0;
    else if (i_ex_wr_en && (i_ex_rd == dec.rs_b) && !i_ex_is_load)
      res_b = i_ex_data;
    else if (i_mem_wr_en && (i_mem_rd == dec.rs_b))
      res_b = i_mem_data;
  end

  // rs_b only matters when it feeds wordB or the shift amount.
  always_comb begin
    hazard = 1'b0;
    if (dec.valid && i_ex_wr_en && i_ex_is_load && (i_ex_rd != C_R0)) begin
      if (i_ex_rd == dec.rs_a)
        hazard = 1'b1;
      else if ((i_ex_rd == dec.rs_b) && (!dec.use_imm || dec.shamt_src))
        hazard = 1'b1;
    end
  end

  assign ready     = !i_flush && !hazard && ((state_q == EMPTY) || i_alu_ready);
  assign accept    = dec.valid && ready;
  assign dec.ready = ready;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    word_a_d  = word_a_q;
    word_b_d  = word_b_q;
    shamt_d   = shamt_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    stall_d   = stall_q;

    // Flush wins over accept and hold; payload is left as-is.
    if (i_flush)
      state_d = EMPTY;
    else if (accept)
      state_d = FULL;
    else if ((state_q == FULL) && i_alu_ready)
      state_d = EMPTY;

    if (accept) begin
      opcode_d  = dec.opcode;
      word_a_d  = res_a;
      word_b_d  = dec.use_imm ? dec.imm : res_b;
      // Shift amount comes from the register value even with an immediate B.
      shamt_d   = dec.shamt_src ? res_b[4:0] : dec.shamt;
      rd_d      = dec.rd;
      illegal_d = (dec.opcode >= C_FIRST_ILLEGAL);
    end

    if (hazard && !i_flush && (stall_q != C_STALL_MAX))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= EMPTY;
      opcode_q  <= '0;
      word_a_q  <= '0;
      word_b_q  <= '0;
      shamt_q   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      word_a_q  <= word_a_d;
      word_b_q  <= word_b_d;
      shamt_q   <= shamt_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
    end
  end

  assign o_alu_valid   = (state_q == FULL);
  assign o_opcode      = opcode_q;
  assign o_wordA       = word_a_q;
  assign o_wordB       = word_b_q;
  assign o_shamt       = shamt_q;
  assign o_rd          = rd_q;
  assign o_illegal     = illegal_q;
  assign o_stall_count = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Directed self-checking bench for alu_issue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  logic                   clk;
  logic                   rst_n;
  logic [REG_ADDR_W-1:0]  rf_addr_a, rf_addr_b;
  logic [31:0]            rf_data_a, rf_data_b;
  logic                   ex_wr_en, ex_is_load, mem_wr_en, flush;
  logic [REG_ADDR_W-1:0]  ex_rd, mem_rd;
  logic [31:0]            ex_data, mem_data;
  logic                   alu_valid, alu_ready, illegal;
  logic [3:0]             opcode;
  logic [31:0]            word_a, word_b;
  logic [4:0]             shamt;
  logic [REG_ADDR_W-1:0]  rd;
  logic [STALL_CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_if #(.REG_ADDR_W(REG_ADDR_W)) dec_if ();

  alu_issue #(
    .REG_ADDR_W (REG_ADDR_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .dec          (dec_if.slave),
    .o_rf_addr_a  (rf_addr_a),
    .o_rf_addr_b  (rf_addr_b),
    .i_rf_data_a  (rf_data_a),
    .i_rf_data_b  (rf_data_b),
    .i_ex_wr_en   (ex_wr_en),
    .i_ex_rd      (ex_rd),
    .i_ex_data    (ex_data),
    .i_ex_is_load (ex_is_load),
    .i_mem_wr_en  (mem_wr_en),
    .i_mem_rd     (mem_rd),
    .i_mem_data   (mem_data),
    .i_flush      (flush),
    .o_alu_valid  (alu_valid),
    .i_alu_ready  (alu_ready),
    .o_opcode     (opcode),
    .o_wordA      (word_a),
    .o_wordB      (word_b),
    .o_shamt      (shamt),
    .o_rd         (rd),
    .o_illegal    (illegal),
    .o_stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    dec_if.valid = 1'b1; dec_if.opcode = 4'h0; dec_if.rs_a = 5'd1; dec_if.rs_b = 5'd0;
    dec_if.rd = 5'd0; dec_if.use_imm = 1'b0; dec_if.imm = 32'h0; dec_if.shamt = 5'd0;
    dec_if.shamt_src = 1'b0;
    rf_data_a = 32'd5; rf_data_b = 32'd0;
    ex_wr_en = 1'b0; ex_rd = '0; ex_data = '0; ex_is_load = 1'b0;
    mem_wr_en = 1'b0; mem_rd = '0; mem_data = '0;
    flush = 1'b0; alu_ready = 1'b1;

    // Reset held two cycles with a valid instruction presented.
    step(); step();
    chk("rst_valid",  {31'd0, alu_valid}, 32'd0);
    chk("rst_wordA",  word_a, 32'd0);
    chk("rst_wordB",  word_b, 32'd0);
    chk("rst_stall",  {16'd0, stall_count}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_rd",     {27'd0, rd}, 32'd0);
    chk("rst_ill",    {31'd0, illegal}, 32'd0);
    chk("rf_addr_a",  {27'd0, rf_addr_a}, 32'd1);

    // Basic ADD r3 = r1 + r2.
    rst_n = 1'b1;
    dec_if.rs_b = 5'd2; dec_if.rd = 5'd3; rf_data_b = 32'd7;
    #1;
    chk("add_ready", {31'd0, dec_if.ready}, 32'd1);
    step();
    chk("add_valid", {31'd0, alu_valid}, 32'd1);
    chk("add_wordA", word_a, 32'd5);
    chk("add_wordB", word_b, 32'd7);
    chk("add_rd",    {27'd0, rd}, 32'd3);
    chk("add_ill",   {31'd0, illegal}, 32'd0);

    // Forwarding priority on source A.
    dec_if.rs_a = 5'd4; rf_data_a = 32'h1111;
    ex_wr_en = 1'b1; ex_rd = 5'd4; ex_data = 32'hAAAA;
    mem_wr_en = 1'b1; mem_rd = 5'd4; mem_data = 32'hBBBB;
    step();
    chk("fwd_ex",    word_a, 32'hAAAA);
    chk("fwd_ex_b",  word_b, 32'd7);
    ex_wr_en = 1'b0;
    step();
    chk("fwd_mem",   word_a, 32'hBBBB);
    ex_wr_en = 1'b1; ex_rd = 5'd0; dec_if.rs_a = 5'd0;
    step();
    chk("fwd_r0",    word_a, 32'd0);

    // Load-use on rs_b: no accept this cycle, one stall counted.
    mem_wr_en = 1'b0; mem_rd = '0;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2; ex_data = 32'hDEAD;
    dec_if.rs_a = 5'd1; rf_data_a = 32'd5; dec_if.rs_b = 5'd2; rf_data_b = 32'h99;
    dec_if.rd = 5'd6; dec_if.opcode = 4'h1;
    #1;
    chk("lu_ready", {31'd0, dec_if.ready}, 32'd0);
    step();
    chk("lu_valid", {31'd0, alu_valid}, 32'd0);
    chk("lu_stall", {16'd0, stall_count}, 32'd1);
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_rd = 5'd2; mem_data = 32'h55;
    #1;
    chk("lu2_ready", {31'd0, dec_if.ready}, 32'd1);
    step();
    chk("lu2_valid", {31'd0, alu_valid}, 32'd1);
    chk("lu2_wordB", word_b, 32'h55);
    chk("lu2_rd",    {27'd0, rd}, 32'd6);
    chk("lu2_stall", {16'd0, stall_count}, 32'd1);

    // Backpressure: new instruction presented but outputs must hold.
    mem_wr_en = 1'b0; mem_rd = '0;
    alu_ready = 1'b0;
    dec_if.opcode = 4'h2; rf_data_a = 32'h77; dec_if.rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'd0, dec_if.ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, alu_valid}, 32'd1);
      chk("bp_wordA", word_a, 32'd5);
      chk("bp_wordB", word_b, 32'h55);
      chk("bp_rd",    {27'd0, rd}, 32'd6);
      chk("bp_op",    {28'd0, opcode}, 32'd1);
    end
    chk("bp_stall", {16'd0, stall_count}, 32'd1);

    // Flush with valid instruction: empties and issues nothing.
    flush = 1'b1; alu_ready = 1'b1;
    step();
    chk("fl_valid", {31'd0, alu_valid}, 32'd0);
    chk("fl_hold",  word_b, 32'h55);
    flush = 1'b0; dec_if.valid = 1'b0;
    step();
    chk("fl_idle",  {31'd0, alu_valid}, 32'd0);

    // Immediate B, register shamt, reserved opcode.
    dec_if.valid = 1'b1; dec_if.opcode = 4'hE; dec_if.rs_a = 5'd1; dec_if.rs_b = 5'd3;
    dec_if.use_imm = 1'b1; dec_if.imm = 32'hFFFF_FFF0; dec_if.shamt_src = 1'b1;
    dec_if.shamt = 5'h1F; rf_data_b = 32'h25; dec_if.rd = 5'd7;
    step();
    chk("imm_wordB", word_b, 32'hFFFF_FFF0);
    chk("imm_shamt", {27'd0, shamt}, 32'd5);
    chk("imm_ill",   {31'd0, illegal}, 32'd1);
    chk("imm_op",    {28'd0, opcode}, 32'hE);

    // Largest legal opcode, immediate shamt, register B.
    dec_if.opcode = 4'hC; dec_if.use_imm = 1'b0; dec_if.shamt_src = 1'b0;
    step();
    chk("c_ill",   {31'd0, illegal}, 32'd0);
    chk("c_shamt", {27'd0, shamt}, 32'h1F);
    chk("c_wordB", word_b, 32'h25);

    // Smallest reserved opcode.
    dec_if.opcode = 4'hD;
    step();
    chk("d_ill", {31'd0, illegal}, 32'd1);

    // Load in EX matching rs_b that feeds nothing: no hazard.
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    dec_if.use_imm = 1'b1; dec_if.shamt_src = 1'b0; dec_if.opcode = 4'h3;
    #1;
    chk("nh_ready", {31'd0, dec_if.ready}, 32'd1);
    step();
    chk("nh_stall", {16'd0, stall_count}, 32'd1);
    chk("nh_op",    {28'd0, opcode}, 32'd3);

    // Same load matching rs_a while flushed: stall must not count.
    dec_if.rs_a = 5'd3; flush = 1'b1;
    step();
    chk("fh_stall", {16'd0, stall_count}, 32'd1);
    chk("fh_valid", {31'd0, alu_valid}, 32'd0);
    flush = 1'b0;
    step();
    chk("ha_stall", {16'd0, stall_count}, 32'd2);

    // Reset mid-handshake while FULL.
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, alu_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_count}, 32'd0);
    chk("mid_rst_wordB", word_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
